// File: rtl/snes_controller_reader.sv
// SNES pad reader: polls the pad at a fixed rate, shifts 16 serial bits out under
// a latch/clock strobe and publishes the 12 real buttons as an active-high word.
module snes_controller_reader #(
  parameter int unsigned TICK_CYCLES = 300,
  parameter int unsigned POLL_CYCLES = 833333
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [11:0] controller_state,
  output logic        state_valid
);

  localparam int unsigned TICK_W  = 12;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned POLL_W  = 20;
  localparam int unsigned SHIFT_W = 16;
  localparam int unsigned BTN_W   = 12;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SHIFT_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [POLL_W-1:0]    poll_q, poll_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [BTN_W-1:0]     ctrl_q, ctrl_d;
  logic                 latch_q, latch_d;
  logic                 sclk_q, sclk_d;
  logic                 valid_q, valid_d;
  logic                 data_meta_q, data_sync_q;
  logic                 poll_start_c;
  logic                 tick_done_c;

  assign poll_start_c = (poll_q == POLL_LAST);
  assign tick_done_c  = (tick_q == TICK_LAST);

  // Free-running poll timer; independent of the frame FSM.
  assign poll_d = poll_start_c ? '0 : poll_q + POLL_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      poll_q      <= '0;
      shift_q     <= '1;
      ctrl_q      <= '0;
      latch_q     <= 1'b0;
      sclk_q      <= 1'b1;
      valid_q     <= 1'b0;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      poll_q      <= poll_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      latch_q     <= latch_d;
      sclk_q      <= sclk_d;
      valid_q     <= valid_d;
      data_meta_q <= snes_data;
      data_sync_q <= data_meta_q;
    end
  end

  // The latch phase spans two ticks; bit_q counts them so tick_q stays 12 bits.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (poll_start_c) begin
          state_d = LATCH;
          tick_d  = '0;
          bit_d   = '0;
          shift_d = '1;
        end
      end
      LATCH: begin
        if (tick_done_c) begin
          tick_d = '0;
          if (bit_q != '0) begin
            bit_d   = '0;
            state_d = CLK_LOW;
          end else begin
            bit_d = BIT_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      CLK_LOW: begin
        if (tick_done_c) begin
          tick_d         = '0;
          shift_d[bit_q] = data_sync_q;
          state_d        = CLK_HIGH;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      CLK_HIGH: begin
        if (tick_done_c) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = CLK_LOW;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they are registered yet aligned with state_q.
  always_comb begin
    latch_d = (state_d == LATCH);
    sclk_d  = (state_d != CLK_LOW);
    valid_d = (state_d == DONE);
    ctrl_d  = valid_d ? ~shift_q[BTN_W-1:0] : ctrl_q;
  end

  assign snes_latch       = latch_q;
  assign snes_clk         = sclk_q;
  assign controller_state = ctrl_q;
  assign state_valid      = valid_q;

endmodule

// File: tb/tb_snes_controller_reader.sv
// Bench for snes_controller_reader: pad model, frame-timing monitor and a
// scoreboard of expected button words popped on each state_valid pulse.
module tb_snes_controller_reader;

  localparam int unsigned TICK = 4;
  localparam int unsigned POLL = 200;
  localparam int unsigned FRAME_TO_VALID = POLL + 2*TICK + 32*TICK;

  logic        clk;
  logic        reset_n;
  logic        snes_data;
  logic        snes_latch;
  logic        snes_clk;
  logic [11:0] controller_state;
  logic        state_valid;

  snes_controller_reader #(
    .TICK_CYCLES(TICK),
    .POLL_CYCLES(POLL)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .snes_data        (snes_data),
    .snes_latch       (snes_latch),
    .snes_clk         (snes_clk),
    .controller_state (controller_state),
    .state_valid      (state_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_pass;
  logic [15:0] pressed;
  bit          window_mode;
  logic [11:0] sb_q[$];
  logic [11:0] held;
  int          n_valid;
  int          cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Pad: presents bit n on the n-th falling snes_clk; window mode makes the level
  // correct only around the one clk edge the 2-flop synchronizer feeds to the sample.
  initial begin
    int   idx;
    logic lvl;
    snes_data = 1'b1;
    idx = 0;
    forever begin
      @(posedge snes_latch or negedge snes_clk);
      if (snes_latch) begin
        idx = 0;
      end else if (idx < 16) begin
        lvl = ~pressed[idx];
        #1;
        if (window_mode) begin
          snes_data = ~lvl;
          @(posedge clk); #1 snes_data = lvl;
          @(posedge clk); #1 snes_data = ~lvl;
        end else begin
          snes_data = lvl;
        end
        idx++;
      end
    end
  end

  // Monitor: strobe widths, pulse count, valid spacing, scoreboard and hold checks.
  initial begin
    int          latch_run, clk_run, pulses, last_valid_cyc;
    bit          aborted, spacing_ok;
    logic        prev_latch, prev_sclk;
    logic [11:0] exp_v;
    latch_run = 0; clk_run = 0; pulses = 0; last_valid_cyc = 0;
    aborted = 1'b1; spacing_ok = 1'b0;
    prev_latch = 1'b0; prev_sclk = 1'b1;
    held = '0; n_valid = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        aborted = 1'b1; spacing_ok = 1'b0; held = '0;
        latch_run = 0; clk_run = 0;
      end else begin
        if (snes_latch) begin
          if (!prev_latch) begin aborted = 1'b0; pulses = 0; end
          latch_run++;
        end else if (prev_latch) begin
          if (!aborted) check_eq("latch_width", 32'(latch_run), 32'(2*TICK));
          latch_run = 0;
        end
        if (!snes_clk) begin
          clk_run++;
        end else if (!prev_sclk) begin
          if (!aborted) begin
            check_eq("sclk_low_width", 32'(clk_run), 32'(TICK));
            pulses++;
          end
          clk_run = 0;
        end
        if (state_valid) begin
          n_valid++;
          check_eq("pulses_per_frame", 32'(pulses), 32'd16);
          check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            exp_v = sb_q.pop_front();
            check_eq("controller_state", 32'(controller_state), 32'(exp_v));
            held = exp_v;
          end
          if (spacing_ok) check_eq("valid_spacing", 32'(cyc - last_valid_cyc), 32'(POLL));
          last_valid_cyc = cyc;
          spacing_ok = 1'b1;
        end else begin
          check_eq("hold", 32'(controller_state), 32'(held));
        end
      end
      prev_latch = snes_latch;
      prev_sclk  = snes_clk;
    end
  end

  task automatic wait_valid(input int budget);
    int start, k;
    start = n_valid;
    k = 0;
    while (n_valid == start && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_valid == start) check_eq("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [15:0] p, input bit w, input logic [11:0] e);
    pressed = p;
    window_mode = w;
    sb_q.push_back(e);
    wait_valid(400);
  endtask

  initial begin
    int   k, cnt;
    logic prev;
    n_checks = 0; n_pass = 0;
    reset_n = 1'b0; pressed = '0; window_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_latch", 32'(snes_latch), 32'd0);
    check_eq("rst_sclk", 32'(snes_clk), 32'd1);
    check_eq("rst_ctrl", 32'(controller_state), 32'd0);
    check_eq("rst_valid", 32'(state_valid), 32'd0);

    sb_q.push_back(12'h000);
    @(posedge clk); #1 reset_n = 1'b1;
    k = 0;
    while (!snes_latch && k < 300) begin @(posedge clk); #1; k++; end
    check_eq("first_latch_cycle", 32'(k), 32'(POLL));
    wait_valid(400);

    run_frame(16'h0889, 1'b0, 12'h889);
    run_frame(16'hF000, 1'b0, 12'h000);
    run_frame(16'h0010, 1'b0, 12'h010);
    run_frame(16'h0020, 1'b0, 12'h020);
    run_frame(16'h5A5C, 1'b1, 12'hA5C);
    run_frame(16'h00F3, 1'b1, 12'h0F3);

    // Abort a frame with reset during bit 7.
    pressed = 16'h0010; window_mode = 1'b0;
    k = 0;
    while (!snes_latch && k < 300) begin @(posedge clk); #1; k++; end
    cnt = 0; prev = snes_clk;
    while (cnt < 8 && k < 600) begin
      @(posedge clk); #1; k++;
      if (prev && !snes_clk) cnt++;
      prev = snes_clk;
    end
    if (cnt < 8) check_eq("bit7_timeout", 32'(cnt), 32'd8);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_sclk", 32'(snes_clk), 32'd1);
    check_eq("abort_latch", 32'(snes_latch), 32'd0);
    check_eq("abort_ctrl", 32'(controller_state), 32'd0);
    check_eq("abort_valid", 32'(state_valid), 32'd0);
    reset_n = 1'b1;
    sb_q.push_back(12'h010);
    k = 0;
    while (!state_valid && k < 500) begin @(posedge clk); #1; k++; end
    check_eq("resume_valid_cycle", 32'(k), 32'(FRAME_TO_VALID));
    @(posedge clk);

    run_frame(16'h0800, 1'b0, 12'h800);
    repeat (4) @(posedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snes_controller_reader.md
SNES_CONTROLLER_READER -- requirements
Module: snes_controller_reader

Interface
REQ-001 Parameter TICK_CYCLES, default 300, clk cycles per 6 us protocol half-period (50 MHz clk); legal range 4..4095.
REQ-002 Parameter POLL_CYCLES, default 833333, clk cycles between poll starts (60 Hz); SHALL exceed 34*TICK_CYCLES+4.
REQ-003 clk  input  1  system clock, single clock domain, all state on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 snes_data  input  1  serial data from pad, asynchronous, active-low (0 = pressed).
REQ-006 snes_latch  output  1  latch strobe to pad, active-high.
REQ-007 snes_clk  output  1  serial clock to pad, idles high.
REQ-008 controller_state  output  12  decoded buttons, active-high: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.
REQ-009 state_valid  output  1  one-cycle pulse when controller_state is updated.

Function
REQ-010 snes_data SHALL pass through a 2-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-011 Free-running poll counter 0..POLL_CYCLES-1 SHALL wrap to 0 and assert a one-cycle poll_start at terminal count; counter runs regardless of FSM state.
REQ-012 FSM states: IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE.
REQ-013 IDLE: snes_latch=0, snes_clk=1; on poll_start -> LATCH, tick counter and bit index cleared to 0.
REQ-014 LATCH: snes_latch=1, snes_clk=1 for exactly 2*TICK_CYCLES cycles -> CLK_LOW.
REQ-015 CLK_LOW: snes_latch=0, snes_clk=0 for TICK_CYCLES cycles; synchronized data SHALL be sampled in the last cycle of CLK_LOW into shift bit [bit index] -> CLK_HIGH.
REQ-016 CLK_HIGH: snes_clk=1 for TICK_CYCLES cycles; if bit index=15 -> DONE, else bit index+1 -> CLK_LOW.
REQ-017 Exactly 16 snes_clk low pulses per frame; bits 12..15 SHALL be sampled but discarded.
REQ-018 DONE (one cycle): controller_state <= ~shift[11:0]; state_valid=1 this cycle only -> IDLE.
REQ-019 Frame length: 2+32 ticks plus 1 cycle; poll_start arriving in any non-IDLE state SHALL be ignored (no restart, no queueing).
REQ-020 controller_state SHALL hold its value between DONE cycles; no partial updates mid-frame.
REQ-021 Tick counter width SHALL be 12 bits; bit index 4 bits; poll counter 20 bits; no counter may overflow within legal parameters.
REQ-022 snes_latch and snes_clk SHALL be registered outputs (glitch-free).

Reset
REQ-023 While reset_n=0 at a rising clk: FSM=IDLE, snes_latch=0, snes_clk=1, controller_state=12'h000, state_valid=0, shift=16'hFFFF, all counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no controller_state update; first poll_start after release occurs POLL_CYCLES cycles after release.

Verification (TICK_CYCLES=4, POLL_CYCLES=200)
REQ-025 Reset, then snes_data held 1 -> first snes_latch rise at cycle 200 after release, high 8 cycles; 16 snes_clk low pulses of 4 cycles; state_valid pulse; controller_state=12'h000.
REQ-026 Pad model drives bits B,Start,Right,R low (others high) -> controller_state=12'h889 after state_valid; held unchanged until next state_valid.
REQ-027 Pad model drives bits 12..15 low, 0..11 high -> controller_state=12'h000 (bits 12..15 ignored).
REQ-028 reset_n=0 for one cycle during bit 7 of a frame with Up pressed -> snes_clk=1, snes_latch=0 next cycle, controller_state=12'h000, no state_valid until the next full frame.
REQ-029 Consecutive frames with Up then Down pressed -> controller_state=12'h010 then 12'h020, exactly one state_valid per 200 cycles.
REQ-030 Toggle snes_data outside sampling cycles only -> sampled values unaffected; 2-cycle synchronizer delay verified against sample point.
